// File: rtl/psram_mem_tester.sv
// Self-test traffic generator for the PSRAM driver: writes pat(i) = i ^ 16'h5A5A over a word range,
// reads the range back, and reports error count and first failing address.
//
// state      | meaning
// IDLE       | waiting for start, results held
// WAIT_QPI   | test armed, waiting for driver QPI mode and idle endcommand
// WR_REQ     | load address/data for index, raise write_sw
// WR_WAIT    | write outstanding, timeout counting
// WR_GAP     | strobes low, wait gap, endcommand low and qpi_on
// RD_REQ     | load address for index, raise read_sw
// RD_WAIT    | read outstanding, timeout counting
// RD_CHECK   | compare captured read data with pattern
// RD_GAP     | strobes low, same exit rule as WR_GAP
// FINISH     | publish done/pass
module psram_mem_tester #(
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter int unsigned WORDS      = 256,
  parameter int unsigned ADDR_STEP  = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned GAP        = 2
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        qpi_on,
  input  logic        endcommand,
  input  logic [15:0] data_out,
  output logic [23:0] address,
  output logic        read_sw,
  output logic        write_sw,
  output logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [23:0] first_err_addr
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_QPI, S_WR_REQ, S_WR_WAIT, S_WR_GAP,
    S_RD_REQ, S_RD_WAIT, S_RD_CHECK, S_RD_GAP, S_FINISH
  } state_t;

  localparam logic [15:0] LAST_IDX  = 16'(WORDS - 1);
  localparam logic [7:0]  TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP);

  state_t      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [23:0] address_q, address_d;
  logic [15:0] data_in_q, data_in_d;
  logic        read_sw_q, read_sw_d;
  logic        write_sw_q, write_sw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] err_count_q, err_count_d;
  logic [23:0] first_err_q, first_err_d;

  logic [23:0] addr_calc;
  logic [15:0] pat;
  logic        err_ev;
  logic        gap_ok;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    rd_data_d   = rd_data_q;
    address_d   = address_q;
    data_in_d   = data_in_q;
    read_sw_d   = read_sw_q;
    write_sw_d  = write_sw_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    err_ev      = 1'b0;

    addr_calc = START_ADDR + 24'(32'(index_q) * 32'(ADDR_STEP));
    pat       = index_q ^ 16'h5A5A;
    // The gap counter also holds the next request back while the driver is busy or out of QPI.
    gap_ok    = (gap_q <= 8'd1) && !endcommand && qpi_on;

    if (gap_q > 8'd1 && (state_q == S_WR_GAP || state_q == S_RD_GAP)) begin
      gap_d = gap_q - 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT_QPI;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = 16'h0000;
          first_err_d = 24'hFFFFFF;
          index_d     = 16'h0000;
        end
      end
      S_WAIT_QPI: begin
        if (qpi_on && !endcommand) state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        address_d  = addr_calc;
        data_in_d  = pat;
        write_sw_d = 1'b1;
        tmo_d      = 8'd0;
        state_d    = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (endcommand || tmo_q == TMO_LIMIT) begin
          err_ev     = !endcommand;
          write_sw_d = 1'b0;
          gap_d      = GAP_LOAD;
          state_d    = S_WR_GAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WR_GAP: begin
        if (gap_ok) begin
          if (index_q == LAST_IDX) begin
            index_d = 16'h0000;
            state_d = S_RD_REQ;
          end else begin
            index_d = index_q + 16'd1;
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        address_d = addr_calc;
        read_sw_d = 1'b1;
        tmo_d     = 8'd0;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (endcommand) begin
          rd_data_d = data_out;
          read_sw_d = 1'b0;
          state_d   = S_RD_CHECK;
        end else if (tmo_q == TMO_LIMIT) begin
          err_ev    = 1'b1;
          read_sw_d = 1'b0;
          gap_d     = GAP_LOAD;
          state_d   = S_RD_GAP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_RD_CHECK: begin
        err_ev  = (rd_data_q != pat);
        gap_d   = GAP_LOAD;
        state_d = S_RD_GAP;
      end
      S_RD_GAP: begin
        if (gap_ok) begin
          if (index_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            index_d = index_q + 16'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_count_q == 16'h0000);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (err_ev) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      if (first_err_q == 24'hFFFFFF) first_err_d = address_q;
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      index_q     <= 16'h0000;
      tmo_q       <= 8'd0;
      gap_q       <= 8'd0;
      rd_data_q   <= 16'h0000;
      address_q   <= 24'h000000;
      data_in_q   <= 16'h0000;
      read_sw_q   <= 1'b0;
      write_sw_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 16'h0000;
      first_err_q <= 24'hFFFFFF;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      rd_data_q   <= rd_data_d;
      address_q   <= address_d;
      data_in_q   <= data_in_d;
      read_sw_q   <= read_sw_d;
      write_sw_q  <= write_sw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign address        = address_q;
  assign read_sw        = read_sw_q;
  assign write_sw       = write_sw_q;
  assign data_in        = data_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_psram_mem_tester.sv
// Bench for psram_mem_tester: behavioural PSRAM driver model with a memory, random latency and
// fault injection; expected results computed from the pattern/address rules.
module tb_psram_mem_tester;

  localparam logic [23:0] T_SA    = 24'h000010;
  localparam int          T_WORDS = 4;
  localparam int          T_STEP  = 2;
  localparam int          T_TMO   = 255;
  localparam int          T_GAP   = 2;

  logic        mem_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic        qpi_on = 1'b0;
  logic        endcommand = 1'b0, endcommand2 = 1'b0;
  logic [15:0] data_out = 16'h0, data_out2 = 16'h0;
  logic [23:0] address, address2, first_err_addr, first_err_addr2;
  logic        read_sw, write_sw, busy, done, pass;
  logic        read_sw2, write_sw2, busy2, done2, pass2;
  logic [15:0] data_in, data_in2, err_count, err_count2;

  int cmp = 0;
  int errs = 0;

  psram_mem_tester #(.START_ADDR(T_SA), .WORDS(T_WORDS), .ADDR_STEP(T_STEP),
                     .TIMEOUT(T_TMO), .GAP(T_GAP)) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .start(start), .qpi_on(qpi_on),
    .endcommand(endcommand), .data_out(data_out), .address(address),
    .read_sw(read_sw), .write_sw(write_sw), .data_in(data_in), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr));

  psram_mem_tester #(.START_ADDR(24'hFFFFFE), .WORDS(2), .ADDR_STEP(2),
                     .TIMEOUT(255), .GAP(2)) dut2 (
    .mem_clk(mem_clk), .rst_n(rst_n), .start(start2), .qpi_on(qpi_on),
    .endcommand(endcommand2), .data_out(data_out2), .address(address2),
    .read_sw(read_sw2), .write_sw(write_sw2), .data_in(data_in2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err_count2), .first_err_addr(first_err_addr2));

  always #5 mem_clk = ~mem_clk;

  // ---------------- driver model for dut ----------------
  logic [15:0] mem [logic [23:0]];
  logic [15:0] cx  [logic [23:0]];
  logic [15:0] xr  [T_WORDS];
  logic [39:0] wlog [$];
  bit          lat_rand = 0, hang_en = 0, seen_prev = 0, prev_strobe = 0;
  logic [23:0] hang_addr = 24'h0, hold_addr = 24'h0;
  logic [15:0] hold_data = 16'h0;
  int          cnt = 0, cur_lat = 4, width_w = 0, max_w_width = 0;
  int          idle_cnt = 0, min_gap = 1000, strobe_seen = 0;

  always @(negedge mem_clk) begin
    if (read_sw && write_sw) begin
      errs++;
      $display("FAIL strobe_overlap: read_sw=%0b write_sw=%0b, required not both high", read_sw, write_sw);
    end
    if (write_sw || read_sw) begin
      if (!prev_strobe) begin
        strobe_seen++;
        if (seen_prev && idle_cnt < min_gap) min_gap = idle_cnt;
        seen_prev = 1;
        idle_cnt  = 0;
        cnt       = 0;
        width_w   = 0;
        cur_lat   = lat_rand ? int'($urandom_range(8, 1)) : 4;
        hold_addr = address;
        hold_data = data_in;
        if (write_sw) wlog.push_back({address, data_in});
      end else if (address !== hold_addr || (write_sw && data_in !== hold_data)) begin
        errs++;
        $display("FAIL strobe_stable: addr=%h data=%h, required %h/%h", address, data_in, hold_addr, hold_data);
      end
      if (write_sw) begin
        width_w++;
        if (width_w > max_w_width) max_w_width = width_w;
      end
      if (cnt < cur_lat) cnt++;
      if (cnt == cur_lat && !(hang_en && write_sw && address == hang_addr)) begin
        endcommand = 1'b1;
        if (write_sw) mem[address] = data_in;
        else data_out = (mem.exists(address) ? mem[address] : 16'h0000) ^
                        (cx.exists(address) ? cx[address] : 16'h0000);
      end
    end else begin
      endcommand = 1'b0;
      if (seen_prev) idle_cnt++;
    end
    prev_strobe = write_sw || read_sw;
  end

  // ---------------- driver model for dut2 ----------------
  logic [15:0] mem2 [logic [23:0]];
  logic [39:0] wlog2 [$];
  bit          prev2 = 0;
  int          cnt2 = 0;

  always @(negedge mem_clk) begin
    if (read_sw2 && write_sw2) begin
      errs++;
      $display("FAIL strobe_overlap2: read_sw=1 write_sw=1, required not both high");
    end
    if (write_sw2 || read_sw2) begin
      if (!prev2) begin
        cnt2 = 0;
        if (write_sw2) wlog2.push_back({address2, data_in2});
      end
      if (cnt2 < 2) cnt2++;
      if (cnt2 == 2) begin
        endcommand2 = 1'b1;
        if (write_sw2) mem2[address2] = data_in2;
        else data_out2 = mem2.exists(address2) ? mem2[address2] : 16'h0000;
      end
    end else begin
      endcommand2 = 1'b0;
    end
    prev2 = write_sw2 || read_sw2;
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] ref_addr(input int i);
    return T_SA + 24'(i * T_STEP);
  endfunction

  function automatic logic [15:0] ref_pat(input int i);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  // Walks the write phase then the read phase in issue order; a hung write leaves memory at 0.
  task automatic ref_result(input int hang, output logic [15:0] e, output logic [23:0] f);
    logic [15:0] rd;
    e = 16'h0;
    f = 24'hFFFFFF;
    for (int i = 0; i < T_WORDS; i++) begin
      if (i == hang) begin
        e++;
        if (f == 24'hFFFFFF) f = ref_addr(i);
      end
    end
    for (int i = 0; i < T_WORDS; i++) begin
      rd = ((i == hang) ? 16'h0000 : ref_pat(i)) ^ xr[i];
      if (rd != ref_pat(i)) begin
        e++;
        if (f == 24'hFFFFFF) f = ref_addr(i);
      end
    end
  endtask

  task automatic clear_model();
    mem.delete();
    cx.delete();
    wlog.delete();
    for (int i = 0; i < T_WORDS; i++) xr[i] = 16'h0;
    hang_en = 0;
    lat_rand = 0;
    seen_prev = 0;
    min_gap = 1000;
    max_w_width = 0;
    strobe_seen = 0;
    idle_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge mem_clk);
    start = 1'b1;
    @(negedge mem_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge mem_clk);
      n++;
    end
    cmp++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL %s_done_wait: done=%b after %0d cycles, required 1", tag, done, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge mem_clk);
    cmp++;
    if ({read_sw, write_sw, busy, done, pass} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags: rd/wr/busy/done/pass=%b, required 00000", {read_sw, write_sw, busy, done, pass});
    end
    cmp++;
    if (address !== 24'h0 || data_in !== 16'h0) begin
      errs++;
      $display("FAIL reset_bus: address=%h data_in=%h, required 0/0", address, data_in);
    end
    cmp++;
    if (err_count !== 16'h0 || first_err_addr !== 24'hFFFFFF) begin
      errs++;
      $display("FAIL reset_err: err=%h first=%h, required 0000/ffffff", err_count, first_err_addr);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge mem_clk);
    cmp++;
    if (busy !== 1'b0 || write_sw !== 1'b0 || first_err_addr2 !== 24'hFFFFFF) begin
      errs++;
      $display("FAIL idle_after_reset: busy=%b wr=%b first2=%h, required 0/0/ffffff", busy, write_sw, first_err_addr2);
    end
  endtask

  task automatic test_basic();
    clear_model();
    qpi_on = 1'b1;
    pulse_start();
    repeat (20) @(negedge mem_clk);
    start = 1'b1;
    @(negedge mem_clk);
    start = 1'b0;
    wait_done(2000, "basic");
    cmp++;
    if (wlog.size() != T_WORDS) begin
      errs++;
      $display("FAIL basic_wr_count: writes=%0d, required %0d", wlog.size(), T_WORDS);
    end else begin
      for (int i = 0; i < T_WORDS; i++) begin
        cmp++;
        if (wlog[i] !== {ref_addr(i), ref_pat(i)}) begin
          errs++;
          $display("FAIL basic_write_%0d: got %h, required %h", i, wlog[i], {ref_addr(i), ref_pat(i)});
        end
      end
    end
    cmp++;
    if (pass !== 1'b1 || err_count !== 16'h0 || first_err_addr !== 24'hFFFFFF || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_result: pass=%b err=%h first=%h busy=%b, required 1/0000/ffffff/0",
               pass, err_count, first_err_addr, busy);
    end
    cmp++;
    if (strobe_seen != 2 * T_WORDS) begin
      errs++;
      $display("FAIL basic_strobes: %0d accesses, required %0d (start while busy ignored)", strobe_seen, 2 * T_WORDS);
    end
    cmp++;
    if (min_gap < T_GAP) begin
      errs++;
      $display("FAIL basic_gap: min idle=%0d, required >= %0d", min_gap, T_GAP);
    end
    repeat (10) @(negedge mem_clk);
    cmp++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errs++;
      $display("FAIL basic_hold: done=%b pass=%b, required 1/1", done, pass);
    end
  endtask

  task automatic test_corrupt_fixed();
    logic [15:0] e;
    logic [23:0] f;
    clear_model();
    xr[2] = 16'h0001;
    cx[ref_addr(2)] = 16'h0001;
    ref_result(-1, e, f);
    pulse_start();
    wait_done(2000, "corrupt");
    cmp++;
    if (err_count !== e || first_err_addr !== f || pass !== 1'b0 || e !== 16'd1 || f !== 24'h000014) begin
      errs++;
      $display("FAIL corrupt_result: err=%h first=%h pass=%b, required %h/%h/0", err_count, first_err_addr, pass, e, f);
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    logic [23:0] f;
    for (int it = 0; it < 5; it++) begin
      clear_model();
      lat_rand = 1;
      for (int i = 0; i < T_WORDS; i++) begin
        xr[i] = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(16'hFFFF, 1)) : 16'h0000;
        if (xr[i] != 16'h0) cx[ref_addr(i)] = xr[i];
      end
      ref_result(-1, e, f);
      pulse_start();
      wait_done(3000, "random");
      cmp++;
      if (err_count !== e || first_err_addr !== f || pass !== (e == 16'h0)) begin
        errs++;
        $display("FAIL random_%0d: err=%h first=%h pass=%b, required %h/%h/%b",
                 it, err_count, first_err_addr, pass, e, f, (e == 16'h0));
      end
    end
  endtask

  task automatic test_write_timeout();
    logic [15:0] e;
    logic [23:0] f;
    clear_model();
    hang_en = 1;
    hang_addr = ref_addr(2);
    ref_result(2, e, f);
    pulse_start();
    wait_done(4000, "timeout");
    cmp++;
    if (err_count !== e || first_err_addr !== f || pass !== 1'b0) begin
      errs++;
      $display("FAIL timeout_result: err=%h first=%h pass=%b, required %h/%h/0", err_count, first_err_addr, pass, e, f);
    end
    cmp++;
    if (max_w_width < T_TMO || max_w_width > T_TMO + 1) begin
      errs++;
      $display("FAIL timeout_width: write_sw high %0d cycles, required %0d..%0d", max_w_width, T_TMO, T_TMO + 1);
    end
  endtask

  task automatic test_qpi_wait();
    clear_model();
    qpi_on = 1'b0;
    pulse_start();
    repeat (1000) @(negedge mem_clk);
    cmp++;
    if (strobe_seen != 0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL qpi_hold: %0d strobes busy=%b before qpi_on, required 0/1", strobe_seen, busy);
    end
    qpi_on = 1'b1;
    wait_done(2000, "qpi");
    cmp++;
    if (pass !== 1'b1 || err_count !== 16'h0) begin
      errs++;
      $display("FAIL qpi_result: pass=%b err=%h, required 1/0000", pass, err_count);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_model();
    pulse_start();
    while (write_sw !== 1'b1 && n < 100) begin
      @(negedge mem_clk);
      n++;
    end
    cmp++;
    if (write_sw !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_strobe: write_sw=%b after %0d cycles, required 1", write_sw, n);
    end
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if (write_sw !== 1'b0 || busy !== 1'b0 || first_err_addr !== 24'hFFFFFF) begin
      errs++;
      $display("FAIL rstmid_async: wr=%b busy=%b first=%h, required 0/0/ffffff", write_sw, busy, first_err_addr);
    end
    @(negedge mem_clk);
    rst_n = 1'b1;
    @(negedge mem_clk);
    clear_model();
    pulse_start();
    wait_done(2000, "rstmid");
    cmp++;
    if (pass !== 1'b1 || err_count !== 16'h0 || wlog.size() != T_WORDS) begin
      errs++;
      $display("FAIL rstmid_rerun: pass=%b err=%h writes=%0d, required 1/0000/%0d", pass, err_count, wlog.size(), T_WORDS);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    wlog2.delete();
    mem2.delete();
    @(negedge mem_clk);
    start2 = 1'b1;
    @(negedge mem_clk);
    start2 = 1'b0;
    while (!done2 && n < 2000) begin
      @(negedge mem_clk);
      n++;
    end
    cmp++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || err_count2 !== 16'h0) begin
      errs++;
      $display("FAIL wrap_result: done=%b pass=%b err=%h, required 1/1/0000", done2, pass2, err_count2);
    end
    cmp++;
    if (wlog2.size() != 2) begin
      errs++;
      $display("FAIL wrap_count: writes=%0d, required 2", wlog2.size());
    end else if (wlog2[0] !== {24'hFFFFFE, 16'h5A5A} || wlog2[1] !== {24'h000000, 16'h5A5B}) begin
      errs++;
      $display("FAIL wrap_addr: got %h %h, required fffffe5a5a 0000005a5b", wlog2[0], wlog2[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt_fixed();
    test_random();
    test_write_timeout();
    test_qpi_wait();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
